ctrl_barrier_gate: RTL and testbench

CTRL_BARRIER_GATE -- requirements
Module: ctrl_barrier_gate

---
 rtl/ctrl_barrier_pkg.sv | 17 +
 rtl/ctrl_barrier_gate_port.sv | 155 +++++++++++++++
 rtl/ctrl_barrier_gate.sv | 58 +++++
 tb/tb_ctrl_barrier_gate.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_barrier_pkg.sv
// Shared types and defaults for ctrl_barrier_gate: per-port FSM state encoding
// and default parameter values. Optional stats build: CTRL_BARRIER_GATE_STATS_EN.
package ctrl_barrier_pkg;

    localparam int DEF_PORT_COUNT = 2;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int FIFO_DEPTH     = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SEND  = 2'd2,
        ST_COOL  = 2'd3
    } gate_state_t;

endpackage

// File: rtl/ctrl_barrier_gate_port.sv
// One gated port: 2-entry FIFO, registered barrier bit and EMPTY/WAIT/SEND/COOL
// release FSM. stall_cnt_o exists only when CTRL_BARRIER_GATE_STATS_EN is defined.
module ctrl_barrier_gate_port
    import ctrl_barrier_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  barrier_i,
    output logic                  s_dec_o,
    output logic [CNT_WIDTH-1:0]  release_cnt_o,
`ifdef CTRL_BARRIER_GATE_STATS_EN
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
`endif
    output gate_state_t           state_o
);

    // Handshakes: a beat moves on a port exactly when valid and ready are both
    // high at the rising clock edge; valid never waits on ready.

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  barrier_q;
    gate_state_t           state_q;
    logic                  m_valid_q;
    logic [CNT_WIDTH-1:0]  rel_cnt_q;
    logic [CNT_WIDTH-1:0]  rel_cnt_d;
    logic                  push;
    logic                  pop;
    logic                  fifo_nonempty;

    // s_ready depends only on registered occupancy, never on m_ready.
    assign s_ready_o     = (count_q != 2'd2);
    assign push          = s_valid_i & s_ready_o;
    assign pop           = m_valid_q & m_ready_i;
    assign fifo_nonempty = (count_q != 2'd0);

    assign m_valid_o     = m_valid_q;
    assign m_data_o      = mem_q[rd_ptr_q];
    assign s_dec_o       = pop;
    assign release_cnt_o = rel_cnt_q;
    assign state_o       = state_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rel_cnt_d = rel_cnt_q;
        if (pop) begin
            rel_cnt_d = rel_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            barrier_q <= 1'b0;
            rel_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q   <= count_d;
            barrier_q <= barrier_i;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    // COOL forces a gap after each release so one barrier update frees one beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fifo_nonempty) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (barrier_q && fifo_nonempty) begin
                        state_q   <= ST_SEND;
                        m_valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        state_q   <= ST_COOL;
                        m_valid_q <= 1'b0;
                    end else if (!barrier_q) begin
                        state_q   <= ST_WAIT;
                        m_valid_q <= 1'b0;
                    end
                end
                ST_COOL: begin
                    state_q <= fifo_nonempty ? ST_WAIT : ST_EMPTY;
                end
                default: begin
                    state_q   <= ST_EMPTY;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CTRL_BARRIER_GATE_STATS_EN
    logic [CNT_WIDTH-1:0] stall_q;
    logic [CNT_WIDTH-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_WAIT) && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: rtl/ctrl_barrier_gate.sv
// Barrier-gated multi-port pass-through: each port releases one buffered beat per
// barrier grant. Defining CTRL_BARRIER_GATE_STATS_EN adds the stall_cnt output.
module ctrl_barrier_gate
    import ctrl_barrier_pkg::*;
#(
    parameter int PORT_COUNT = DEF_PORT_COUNT,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_COUNT-1:0]            s_valid,
    output logic [PORT_COUNT-1:0]            s_ready,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_data,
    output logic [PORT_COUNT-1:0]            m_valid,
    input  logic [PORT_COUNT-1:0]            m_ready,
    output logic [PORT_COUNT*DATA_WIDTH-1:0] m_data,
    input  logic [PORT_COUNT:0]              ctrl_barrier,
    output logic [PORT_COUNT-1:0]            s_dec,
    output logic [PORT_COUNT*CNT_WIDTH-1:0]  release_cnt,
`ifdef CTRL_BARRIER_GATE_STATS_EN
    output logic [PORT_COUNT*CNT_WIDTH-1:0]  stall_cnt,
`endif
    output logic [PORT_COUNT*2-1:0]          dbg_state
);

    // The top barrier bit carries no meaning for this block.
    logic unused_barrier_top;
    assign unused_barrier_top = ctrl_barrier[PORT_COUNT];

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        gate_state_t port_state;

        ctrl_barrier_gate_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_port (
            .clk           (clk),
            .rst           (rst),
            .s_valid_i     (s_valid[p]),
            .s_ready_o     (s_ready[p]),
            .s_data_i      (s_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .m_valid_o     (m_valid[p]),
            .m_ready_i     (m_ready[p]),
            .m_data_o      (m_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .barrier_i     (ctrl_barrier[p]),
            .s_dec_o       (s_dec[p]),
            .release_cnt_o (release_cnt[p*CNT_WIDTH +: CNT_WIDTH]),
`ifdef CTRL_BARRIER_GATE_STATS_EN
            .stall_cnt_o   (stall_cnt[p*CNT_WIDTH +: CNT_WIDTH]),
`endif
            .state_o       (port_state)
        );

        assign dbg_state[p*2 +: 2] = port_state;
    end

endmodule

// File: tb/tb_ctrl_barrier_gate.sv
// Self-checking bench for ctrl_barrier_gate: queue-based behavioural model per port,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ctrl_barrier_gate;

    localparam int PC = 2;
    localparam int DW = 16;
    localparam int CW = 4;

    localparam int M_EMPTY = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SEND  = 2;
    localparam int M_COOL  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC-1:0]     s_valid;
    logic [PC-1:0]     s_ready;
    logic [PC*DW-1:0]  s_data;
    logic [PC-1:0]     m_valid;
    logic [PC-1:0]     m_ready;
    logic [PC*DW-1:0]  m_data;
    logic [PC:0]       ctrl_barrier;
    logic [PC-1:0]     s_dec;
    logic [PC*CW-1:0]  release_cnt;
    logic [PC*2-1:0]   unused_dbg_state;

    always #5 clk = ~clk;

    ctrl_barrier_gate #(
        .PORT_COUNT (PC),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .ctrl_barrier (ctrl_barrier),
        .s_dec        (s_dec),
        .release_cnt  (release_cnt),
        .dbg_state    (unused_dbg_state)
    );

    // Model: per-port beat queue (scoreboard), phase, registered barrier, releases.
    logic [DW-1:0] exp_q [PC][$];
    int            mst      [PC];
    bit            mbq      [PC];
    int            mrel     [PC];
    int            sdec_cnt [PC];
    bit            prev_dec [PC];
    int            vectors     = 0;
    int            miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int p = 0; p < PC; p++) begin
            exp_q[p].delete();
            mst[p]      = M_EMPTY;
            mbq[p]      = 1'b0;
            mrel[p]     = 0;
            prev_dec[p] = 1'b0;
        end
    endfunction

    task automatic compare_all();
        for (int p = 0; p < PC; p++) begin
            bit exp_mv;
            bit exp_dec;
            exp_mv  = (mst[p] == M_SEND);
            exp_dec = exp_mv && m_ready[p];
            check($sformatf("s_ready[%0d]", p), 64'(s_ready[p]), 64'(exp_q[p].size() < 2));
            check($sformatf("m_valid[%0d]", p), 64'(m_valid[p]), 64'(exp_mv));
            check($sformatf("s_dec[%0d]", p), 64'(s_dec[p]), 64'(exp_dec));
            check($sformatf("release_cnt[%0d]", p), 64'(release_cnt[p*CW +: CW]),
                  64'(mrel[p] % (1 << CW)));
            if (exp_mv) begin
                check($sformatf("m_data[%0d]", p), 64'(m_data[p*DW +: DW]), 64'(exp_q[p][0]));
            end
            if (s_dec[p]) begin
                check($sformatf("dec_spacing[%0d]", p), 64'(prev_dec[p]), 64'd0);
                sdec_cnt[p]++;
            end
            prev_dec[p] = s_dec[p];
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_clear();
            return;
        end
        for (int p = 0; p < PC; p++) begin
            int sz;
            int ns;
            bit pop;
            bit push;
            sz   = exp_q[p].size();
            pop  = (mst[p] == M_SEND) && m_ready[p];
            push = s_valid[p] && (sz < 2);
            ns   = mst[p];
            case (mst[p])
                M_EMPTY: ns = (sz > 0) ? M_WAIT : M_EMPTY;
                M_WAIT:  ns = (mbq[p] && sz > 0) ? M_SEND : M_WAIT;
                M_SEND:  ns = pop ? M_COOL : (mbq[p] ? M_SEND : M_WAIT);
                default: ns = (sz > 0) ? M_WAIT : M_EMPTY;
            endcase
            if (pop) begin
                void'(exp_q[p].pop_front());
                mrel[p]++;
            end
            if (push) begin
                exp_q[p].push_back(s_data[p*DW +: DW]);
            end
            mst[p] = ns;
            mbq[p] = ctrl_barrier[p];
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic cycle();
        #1 compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic drive(input logic [PC-1:0] sv, input logic [PC-1:0] mr, input logic [PC:0] cb);
        s_valid      = sv;
        m_ready      = mr;
        ctrl_barrier = cb;
        s_data       = PC*DW'($urandom());
    endtask

    initial begin
        int rel_before0;
        int rel_before1;
        int guard;

        rst = 1'b1;
        drive('0, '0, '0);
        for (int p = 0; p < PC; p++) sdec_cnt[p] = 0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check("reset_s_ready", 64'(s_ready), 64'h3);
        check("reset_m_valid", 64'(m_valid), 64'h0);
        check("reset_s_dec", 64'(s_dec), 64'h0);
        check("reset_release_cnt", 64'(release_cnt), 64'h0);
        check("reset_m_data", 64'(m_data), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Closed barrier: port 0 fills and stalls.
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, 2'b00, 3'b000);
            cycle();
        end
        check("fill_model_depth", 64'(exp_q[0].size()), 64'd2);
        check("fill_s_ready0", 64'(s_ready[0]), 64'd0);
        check("fill_m_valid0", 64'(m_valid[0]), 64'd0);
        check("fill_no_dec", 64'(sdec_cnt[0]), 64'd0);

        // Barrier rises: valid two edges later, one pulse, then COOL gap.
        drive(2'b00, 2'b01, 3'b001);
        cycle();
        drive(2'b00, 2'b01, 3'b001);
        cycle();
        check("grant_m_valid0", 64'(m_valid[0]), 64'd1);
        check("grant_s_dec0", 64'(s_dec[0]), 64'd1);
        drive(2'b00, 2'b01, 3'b001);
        cycle();
        check("cool_m_valid0", 64'(m_valid[0]), 64'd0);
        check("cool_release_cnt0", 64'(release_cnt[CW-1:0]), 64'd1);

        // Open barrier with continuous traffic on both ports.
        for (int i = 0; i < 60; i++) begin
            drive(2'b11, 2'b11, 3'b011);
            cycle();
        end

        // Only port 1 granted; top barrier bit toggles freely.
        rel_before0 = mrel[0];
        rel_before1 = mrel[1];
        for (int i = 0; i < 30; i++) begin
            drive(2'b11, 2'b11, {1'($urandom_range(0, 1)), 2'b10});
            cycle();
        end
        check("p0_stalled_cnt", 64'(release_cnt[CW-1:0]), 64'(rel_before0 % (1 << CW)));
        check("p0_stalled_ready", 64'(s_ready[0]), 64'd0);
        check("p0_stalled_valid", 64'(m_valid[0]), 64'd0);
        check("p1_drained", 64'((mrel[1] - rel_before1) >= 5), 64'd1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            drive(PC'($urandom()), PC'($urandom()), (PC+1)'($urandom()));
            cycle();
        end

        // Reset with two beats buffered and downstream ready.
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 2'b01, 3'b000);
            cycle();
        end
        check("prereset_depth", 64'(exp_q[0].size()), 64'd2);
        rst = 1'b1;
        #1;
        check("midreset_s_ready", 64'(s_ready), 64'h3);
        check("midreset_m_valid", 64'(m_valid), 64'h0);
        check("midreset_s_dec", 64'(s_dec), 64'h0);
        model_clear();
        drive(2'b00, 2'b11, 3'b011);
        cycle();
        rst = 1'b0;

        // Sixteen releases on a 4-bit counter wrap it back to zero.
        guard = 0;
        while (mrel[0] < 16 && guard < 300) begin
            drive(2'b01, 2'b01, 3'b001);
            cycle();
            guard++;
        end
        check("wrap_in_time", 64'(guard < 300), 64'd1);
        check("wrap_release_cnt0", 64'(release_cnt[CW-1:0]), 64'd0);

        drive('0, '0, '0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
